// File: rtl/bsg_unpermute_box_pipe.sv
// ----------------------------------------------------------------------------
// bsg_unpermute_box_pipe
//
// Purpose:
//   Scatter partner of the permute box. A permute box gathers
//   (out[i] = in[sel[i]]). This block scatters with the same select vector
//   (out[sel[i]] = in[i]), so feeding a permute box result back through it
//   with the same select recovers the original vector.
//   It is a two-stage registered pipeline with a valid/ready input handshake
//   and a valid/yumi output handshake. It also flags select vectors that are
//   not true permutations.
//
// Parameters:
//   width_p    bits per element
//   els_p      number of elements (>= 2, need not be a power of 2)
//   lg_els_lp  width of one select field, derived from els_p
//
// Ports:
//   clk_i     in   clock, all state updates on the rising edge
//   reset_i   in   synchronous, active-high reset
//   v_i       in   input valid
//   ready_o   out  input ready; a transfer happens when v_i & ready_o
//   data_i    in   element i at data_i[i*width_p +: width_p]
//   select_i  in   destination of element i at select_i[i*lg_els_lp +: lg_els_lp]
//   v_o       out  output valid
//   data_o    out  scattered vector, slot j at data_o[j*width_p +: width_p]
//   err_o     out  select was not a permutation; qualified by v_o
//   yumi_i    in   consumer takes the output; only legal while v_o = 1
// ----------------------------------------------------------------------------
module bsg_unpermute_box_pipe #(
    parameter int unsigned width_p = 1,
    parameter int unsigned els_p   = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [els_p*width_p-1:0]       data_i,
    input  logic [els_p*$clog2(els_p)-1:0] select_i,

    output logic                           v_o,
    output logic [els_p*width_p-1:0]       data_o,
    output logic                           err_o,
    input  logic                           yumi_i
);

    localparam int unsigned lg_els_lp = $clog2(els_p);

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                           r_s1_v;
    logic [els_p*width_p-1:0]       r_s1_data;
    logic [els_p*lg_els_lp-1:0]     r_s1_sel;

    logic                           r_s2_v;
    logic [els_p*width_p-1:0]       r_data_o;
    logic                           r_err_o;

    // ------------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------------
    logic w_yumi;
    logic w_s2_load;
    logic w_s1_accept;
    logic w_ready;

    // An illegal yumi while S2 is empty must not disturb the pipeline.
    assign w_yumi      = yumi_i & r_s2_v;

    // S2 takes the S1 item whenever S2 is empty or is being drained this cycle.
    assign w_s2_load   = r_s1_v & (~r_s2_v | w_yumi);

    // Space exists if S1 is empty, or if S1 will move forward this cycle.
    // Depends only on state and yumi_i, never on v_i.
    assign w_ready     = ~r_s1_v | ~r_s2_v | w_yumi;
    assign w_s1_accept = v_i & w_ready;

    // ------------------------------------------------------------------------
    // Scatter network, evaluated on the S1 contents
    // ------------------------------------------------------------------------
    logic [lg_els_lp-1:0]     w_sel  [els_p];
    logic [width_p-1:0]       w_elem [els_p];

    logic [els_p*width_p-1:0] w_scatter;
    logic [els_p-1:0]         w_hit;     // slot j written by at least one element
    logic [els_p-1:0]         w_multi;   // slot j written by more than one element
    logic [els_p-1:0]         w_placed;  // element i landed in some valid slot
    logic                     w_err;

    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            w_sel[i]  = r_s1_sel[i*lg_els_lp +: lg_els_lp];
            w_elem[i] = r_s1_data[i*width_p +: width_p];
        end
    end

    // Elements are visited in ascending order, so on a collision the highest
    // index overwrites the slot last and wins. An element whose select is out
    // of range matches no slot; it stays unplaced and is dropped.
    always_comb begin
        w_scatter = '0;
        w_hit     = '0;
        w_multi   = '0;
        w_placed  = '0;
        for (int j = 0; j < els_p; j++) begin
            for (int i = 0; i < els_p; i++) begin
                if (w_sel[i] == lg_els_lp'(j)) begin
                    w_multi[j]                      = w_multi[j] | w_hit[j];
                    w_hit[j]                        = 1'b1;
                    w_placed[i]                     = 1'b1;
                    w_scatter[j*width_p +: width_p] = w_elem[i];
                end
            end
        end
    end

    // Not a permutation: an element was dropped, a slot was hit twice, or a
    // slot was never hit.
    assign w_err = ~(&w_placed) | (|w_multi) | ~(&w_hit);

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_sel  <= '0;
            r_s2_v    <= 1'b0;
            r_data_o  <= '0;
            r_err_o   <= 1'b0;
        end else begin
            if (w_s1_accept) begin
                r_s1_data <= data_i;
                r_s1_sel  <= select_i;
            end
            r_s1_v <= w_s1_accept | (r_s1_v & ~w_s2_load);

            // Output registers only change on a load, so they hold while
            // the consumer stalls.
            if (w_s2_load) begin
                r_data_o <= w_scatter;
                r_err_o  <= w_err;
            end
            r_s2_v <= w_s2_load | (r_s2_v & ~w_yumi);
        end
    end

    assign ready_o = w_ready;
    assign v_o     = r_s2_v;
    assign data_o  = r_data_o;
    assign err_o   = r_err_o;

    // The consumer may only take an output that is actually valid.
    a_yumi_needs_valid : assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> r_s2_v
    );

endmodule

// File: tb/tb_bsg_unpermute_box_pipe.sv
// ----------------------------------------------------------------------------
// tb_bsg_unpermute_box_pipe
//
// Purpose:
//   Self-checking bench for bsg_unpermute_box_pipe. One instance with
//   els_p=4, width_p=8 and one with els_p=3, width_p=8 (non-power-of-2).
//   Inputs change 1 time unit after the rising edge; registered outputs are
//   checked at that point, and ready_o one further time unit later.
// ----------------------------------------------------------------------------
module tb_bsg_unpermute_box_pipe;

    logic clk_i;
    logic reset_i;

    // els_p = 4 instance
    logic        a_v_i;
    logic        a_ready_o;
    logic [31:0] a_data_i;
    logic [7:0]  a_sel_i;
    logic        a_v_o;
    logic [31:0] a_data_o;
    logic        a_err_o;
    logic        a_yumi_i;
    logic        a_yumi_en;

    // els_p = 3 instance
    logic        b_v_i;
    logic        b_ready_o;
    logic [23:0] b_data_i;
    logic [5:0]  b_sel_i;
    logic        b_v_o;
    logic [23:0] b_data_o;
    logic        b_err_o;
    logic        b_yumi_i;
    logic        b_yumi_en;

    int n_vec;
    int n_miss;

    // Only present yumi when there is something to take.
    assign a_yumi_i = a_yumi_en & a_v_o;
    assign b_yumi_i = b_yumi_en & b_v_o;

    bsg_unpermute_box_pipe #(
        .width_p(8),
        .els_p  (4)
    ) u_dut_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (a_v_i),
        .ready_o (a_ready_o),
        .data_i  (a_data_i),
        .select_i(a_sel_i),
        .v_o     (a_v_o),
        .data_o  (a_data_o),
        .err_o   (a_err_o),
        .yumi_i  (a_yumi_i)
    );

    bsg_unpermute_box_pipe #(
        .width_p(8),
        .els_p  (3)
    ) u_dut_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (b_v_i),
        .ready_o (b_ready_o),
        .data_i  (b_data_i),
        .select_i(b_sel_i),
        .v_o     (b_v_o),
        .data_o  (b_data_o),
        .err_o   (b_err_o),
        .yumi_i  (b_yumi_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Independent scatter reference: for each slot search from the highest
    // element down and take the first match; flag any slot not hit exactly once.
    function automatic logic [32:0] scatter_model(input logic [31:0] d, input logic [7:0] s);
        logic [31:0] o;
        logic        e;
        int          cnt;
        o = '0;
        e = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cnt = 0;
            for (int i = 3; i >= 0; i--) begin
                if (s[i*2 +: 2] == 2'(j)) begin
                    if (cnt == 0) o[j*8 +: 8] = d[i*8 +: 8];
                    cnt++;
                end
            end
            if (cnt != 1) e = 1'b1;
        end
        return {e, o};
    endfunction

    // One item through an idle els_p=4 pipe with yumi enabled; entered and
    // left at 1 time unit after a rising edge.
    task automatic run_a(input string tag, input logic [31:0] d, input logic [7:0] s,
                         input logic [31:0] exp_d, input logic exp_e);
        a_v_i    = 1'b1;
        a_data_i = d;
        a_sel_i  = s;
        #1;
        check_val({tag, "_ready"}, 64'(a_ready_o), 64'd1);
        tick();
        a_v_i = 1'b0;
        check_val({tag, "_v_t1"}, 64'(a_v_o), 64'd0);
        tick();
        check_val({tag, "_v_t2"}, 64'(a_v_o), 64'd1);
        check_val({tag, "_data"}, 64'(a_data_o), 64'(exp_d));
        check_val({tag, "_err"}, 64'(a_err_o), 64'(exp_e));
        tick();
        check_val({tag, "_v_drained"}, 64'(a_v_o), 64'd0);
    endtask

    task automatic run_b(input string tag, input logic [23:0] d, input logic [5:0] s,
                         input logic [23:0] exp_d, input logic exp_e);
        b_v_i    = 1'b1;
        b_data_i = d;
        b_sel_i  = s;
        #1;
        check_val({tag, "_ready"}, 64'(b_ready_o), 64'd1);
        tick();
        b_v_i = 1'b0;
        tick();
        check_val({tag, "_v"}, 64'(b_v_o), 64'd1);
        check_val({tag, "_data"}, 64'(b_data_o), 64'(exp_d));
        check_val({tag, "_err"}, 64'(b_err_o), 64'(exp_e));
        tick();
        check_val({tag, "_v_drained"}, 64'(b_v_o), 64'd0);
    endtask

    initial begin
        logic [1:0]  p [4];
        logic [1:0]  tmp;
        int          r;
        logic [32:0] exp_q [20];

        n_vec     = 0;
        n_miss    = 0;
        reset_i   = 1'b1;
        a_v_i     = 1'b0;
        a_data_i  = '0;
        a_sel_i   = '0;
        a_yumi_en = 1'b0;
        b_v_i     = 1'b0;
        b_data_i  = '0;
        b_sel_i   = '0;
        b_yumi_en = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_v", 64'(a_v_o), 64'd0);
        check_val("rst_err", 64'(a_err_o), 64'd0);
        check_val("rst_data", 64'(a_data_o), 64'd0);
        reset_i = 1'b0;
        #1;
        check_val("rst_ready", 64'(a_ready_o), 64'd1);
        tick();
        a_yumi_en = 1'b1;
        b_yumi_en = 1'b1;

        // ---------------- directed scatter cases ----------------
        // identity: select {3,2,1,0}
        run_a("identity", 32'h44332211, 8'hE4, 32'h44332211, 1'b0);
        // reverse: select {0,1,2,3}
        run_a("reverse", 32'h44332211, 8'h1B, 32'h11223344, 1'b0);
        // select {1,3,0,2}: gather of 44332211 gives 22441133; scatter restores it
        run_a("roundtrip", 32'h22441133, 8'h72, 32'h44332211, 1'b0);
        // select {0,0,2,1}: slot0 hit by 3 and 2 (3 wins), slot3 never hit
        run_a("collision", 32'h44332211, 8'h09, 32'h00221144, 1'b1);

        // ---------------- backpressure ----------------
        a_yumi_en = 1'b0;
        a_v_i     = 1'b1;
        a_data_i  = 32'h04030201;
        a_sel_i   = 8'hE4;
        #1;
        check_val("bp_ready0", 64'(a_ready_o), 64'd1);
        tick();
        check_val("bp_v_c1", 64'(a_v_o), 64'd0);
        a_data_i = 32'h08070605;
        a_sel_i  = 8'h1B;
        #1;
        check_val("bp_ready1", 64'(a_ready_o), 64'd1);
        tick();
        check_val("bp_v_c2", 64'(a_v_o), 64'd1);
        check_val("bp_data_a", 64'(a_data_o), 64'h04030201);
        a_data_i = 32'hAABBCCDD;
        a_sel_i  = 8'hE4;
        #1;
        check_val("bp_full", 64'(a_ready_o), 64'd0);
        tick();
        check_val("bp_stall_v", 64'(a_v_o), 64'd1);
        check_val("bp_stall_data", 64'(a_data_o), 64'h04030201);
        check_val("bp_stall_err", 64'(a_err_o), 64'd0);
        #1;
        check_val("bp_still_full", 64'(a_ready_o), 64'd0);
        a_yumi_en = 1'b1;
        #1;
        check_val("bp_pass_space", 64'(a_ready_o), 64'd1);
        tick();
        a_v_i = 1'b0;
        check_val("bp_v_b", 64'(a_v_o), 64'd1);
        check_val("bp_data_b", 64'(a_data_o), 64'h05060708);
        tick();
        check_val("bp_v_c", 64'(a_v_o), 64'd1);
        check_val("bp_data_c", 64'(a_data_o), 64'hAABBCCDD);
        tick();
        check_val("bp_empty", 64'(a_v_o), 64'd0);

        // ---------------- streaming ----------------
        for (int c = 0; c < 22; c++) begin
            if (c >= 2) begin
                check_val("str_v", 64'(a_v_o), 64'd1);
                check_val("str_data", 64'(a_data_o), 64'(exp_q[c-2][31:0]));
                check_val("str_err", 64'(a_err_o), 64'(exp_q[c-2][32]));
            end
            if (c < 20) begin
                for (int k = 0; k < 4; k++) p[k] = 2'(k);
                for (int k = 3; k > 0; k--) begin
                    r    = int'($urandom_range(k, 0));
                    tmp  = p[k];
                    p[k] = p[r];
                    p[r] = tmp;
                end
                a_v_i    = 1'b1;
                a_sel_i  = {p[3], p[2], p[1], p[0]};
                a_data_i = $urandom;
                exp_q[c] = scatter_model(a_data_i, a_sel_i);
                #1;
                check_val("str_ready", 64'(a_ready_o), 64'd1);
            end else begin
                a_v_i = 1'b0;
            end
            tick();
        end
        check_val("str_done", 64'(a_v_o), 64'd0);

        // ---------------- reset mid-flight ----------------
        a_yumi_en = 1'b0;
        a_v_i     = 1'b1;
        a_data_i  = 32'h44332211;
        a_sel_i   = 8'h09;
        tick();
        a_data_i  = 32'h55667788;
        a_sel_i   = 8'hE4;
        tick();
        a_v_i = 1'b0;
        check_val("mid_v_before", 64'(a_v_o), 64'd1);
        check_val("mid_err_before", 64'(a_err_o), 64'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_val("mid_v", 64'(a_v_o), 64'd0);
        check_val("mid_err", 64'(a_err_o), 64'd0);
        check_val("mid_data", 64'(a_data_o), 64'd0);
        #1;
        check_val("mid_ready", 64'(a_ready_o), 64'd1);
        a_yumi_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("mid_no_stale", 64'(a_v_o), 64'd0);
        end

        // ---------------- els_p = 3 ----------------
        // select {0,2,1}: valid permutation
        run_b("e3_perm", 24'hCCBBAA, 6'h09, 24'hBBAACC, 1'b0);
        // select {3,1,0}: element 2 out of range and dropped, slot 2 empty
        run_b("e3_oor", 24'hCCBBAA, 6'h34, 24'h00BBAA, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
